spi_ram: RTL and testbench
==========================

# spi_ram

Single-port synchronous RAM that sits directly downstream of the SPI slave, consuming its 10-bit parallel command words and returning read data for serialisation on MISO. Decodes the two command bits of each word into write-address, write-data, read-address and read-data operations. Holds `tx_valid` for a fixed window so the slave can shift out all 8 data bits.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, 8: address width; `ADDR_SIZE` ≤ 8.
- `TX_HOLD`, 9: cycles `tx_valid` stays high per read-data command; must be ≥ 9.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input 10: command word from SPI slave; [9:8] = command, [7:0] = address/data.
- `rx_valid` input 1: `din` valid; sampled every rising edge.
- `dout` output 8: read data to SPI slave.
- `tx_valid` output 1: `dout` valid; held for the TX_HOLD window.

## Operation
- Commands, decoded only on a cycle with `rx_valid`=1:
  - `din[9:8]`=00 (WR_ADDR): `wr_addr` ← `din[ADDR_SIZE-1:0]`.
  - `din[9:8]`=01 (WR_DATA): `mem[wr_addr]` ← `din[7:0]`.
  - `din[9:8]`=10 (RD_ADDR): `rd_addr` ← `din[ADDR_SIZE-1:0]`.
  - `din[9:8]`=11 (RD_DATA): `dout` ← `mem[rd_addr]`; start the TX window. `din[7:0]` is a dummy value and is ignored.
- `din[7:ADDR_SIZE]` is ignored when `ADDR_SIZE` < 8.
- TX FSM states:
  - IDLE: `tx_valid`=0. On RD_DATA go to HOLD and load `hold_cnt`=TX_HOLD-1.
  - HOLD: `tx_valid`=1. `hold_cnt` decrements each cycle; at `hold_cnt`=0 return to IDLE.
- RD_DATA during HOLD: reload `dout` and `hold_cnt`; `tx_valid` stays high with no gap.
- WR_ADDR, WR_DATA and RD_ADDR during HOLD: executed normally; `tx_valid` and `dout` are unaffected.
- `rx_valid`=0: no state change except the hold countdown.
- Reset values:
  - `dout`=0, `tx_valid`=0, `wr_addr`=0, `rd_addr`=0, FSM=IDLE, `hold_cnt`=0.
  - Memory contents are not reset.
- Reset asserted mid-HOLD: `tx_valid` drops immediately (asynchronously). Any pending window is discarded.

## Timing
- WR_DATA: memory is written on the same edge that samples `rx_valid`=1. A read of that address issued on a later cycle returns the new value.
- RD_DATA: `dout` and `tx_valid` update on the edge that samples the command, so they are visible one cycle after `rx_valid`. `tx_valid` is then high for exactly TX_HOLD consecutive cycles.
- `dout` is a snapshot taken at the RD_DATA edge. A later write to `rd_addr` does not change `dout` within the window.
- Back-to-back `rx_valid` on consecutive cycles is legal. Each word is processed independently in order.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - After each WR_DATA, `wr_addr` ← `wr_addr`+1 modulo MEM_DEPTH.
  - After each RD_DATA, `rd_addr` ← `rd_addr`+1 modulo MEM_DEPTH.
  - Address MEM_DEPTH-1 wraps to 0.
- `SPI_RAM_AUTOINC_EN` not defined: addresses change only on WR_ADDR/RD_ADDR.

## Structure
- Package `spi_ram_pkg`:
  - Command enum typedef `spi_cmd_t`: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - TX FSM state typedef.
  - Default constants for MEM_DEPTH, ADDR_SIZE and TX_HOLD.
- Sub-module `spi_ram_tx_timer`: the IDLE/HOLD FSM and `hold_cnt`.
  - Inputs: `clk`, `rst_n`, `start`.
  - Output: `tx_valid`.
  - Parameter: `TX_HOLD`.
- Top level: command decode, address registers, memory array and `dout` register.

## Test plan
- Reset check: `rst_n`=0 mid-operation -> `dout`=0, `tx_valid`=0 immediately; the next RD_DATA with no RD_ADDR returns `mem[0]`.
- Write/read: `din`=0x000|0x25, then 0x100|0xA5, then 0x200|0x25, then 0x300 -> `dout`=0xA5 one cycle after the last `rx_valid`, `tx_valid` high for 9 cycles.
- Snapshot: read addr 0x25, then WR_DATA 0x5A to 0x25 during HOLD -> `dout` stays 0xA5 until the window ends; the next RD_DATA returns 0x5A.
- Re-trigger: second RD_DATA issued 4 cycles into HOLD -> `tx_valid` continuous for 4+9=13 cycles, `dout` reloaded.
- Command interleave: WR_ADDR 0x10 during HOLD -> `tx_valid` unaffected, later WR_DATA lands at 0x10.
- `SPI_RAM_AUTOINC_EN`: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> `mem[0xFF]`=0x11, `mem[0x00]`=0x22.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types and default sizing for the SPI-attached RAM.
// Optional feature macro: SPI_RAM_AUTOINC_EN (address auto-increment).
package spi_ram_pkg;

    // Default geometry. MEM_DEPTH must equal 2**ADDR_SIZE, so address
    // arithmetic wraps naturally at the top of the array.
    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_TX_HOLD   = 9;

    // Command encoding carried in din[9:8].
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_t;

    // TX window FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } tx_state_t;

endpackage : spi_ram_pkg

// File: rtl/spi_ram_if.sv
// spi_ram_if: parallel word link between the SPI slave (master side)
// and the RAM (slave side).
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    // SPI slave: presents command words, consumes read data.
    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid
    );

    // RAM: consumes command words, returns read data.
    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid
    );
endinterface : spi_ram_if

// File: rtl/spi_ram_tx_timer.sv
// spi_ram_tx_timer: holds tx_valid high for TX_HOLD cycles after each
// start pulse. A start during the window restarts the count without a gap.
module spi_ram_tx_timer
    import spi_ram_pkg::*;
#(
    parameter int TX_HOLD = DEF_TX_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic tx_valid
);

    localparam int               CNT_W  = $clog2(TX_HOLD);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TX_HOLD - 1);

    tx_state_t        state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             tx_valid_q;

    // IDLE/HOLD window FSM; tx_valid is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= RELOAD;
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (start) begin
                        hold_cnt_q <= RELOAD;
                    end else if (hold_cnt_q == '0) begin
                        state_q    <= ST_IDLE;
                        tx_valid_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    hold_cnt_q <= '0;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid = tx_valid_q;

endmodule : spi_ram_tx_timer

// File: rtl/spi_ram.sv
// spi_ram: single-port RAM fed by 10-bit SPI command words. Decodes
// write-address / write-data / read-address / read-data commands and
// returns a registered read snapshot with a fixed-length tx_valid window.
// Optional feature macro: SPI_RAM_AUTOINC_EN -- when defined, wr_addr
// advances after each WR_DATA and rd_addr after each RD_DATA.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int TX_HOLD   = DEF_TX_HOLD
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_ram_if.slave  bus
);

    logic [7:0]           mem [0:MEM_DEPTH-1];

    spi_cmd_t             cmd;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]           dout_q;
    logic                 mem_we;
    logic                 rd_en;
    logic                 tx_valid;

    // Command decode: next address values and write/read strobes.
    always_comb begin
        cmd       = spi_cmd_t'(bus.din[9:8]);
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = bus.din[ADDR_SIZE-1:0];
                CMD_WR_DATA: begin
                    mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    // Depth is a power of two, so the add wraps to 0.
                    wr_addr_d = wr_addr_q + 1'b1;
`endif
                end
                CMD_RD_ADDR: rd_addr_d = bus.din[ADDR_SIZE-1:0];
                CMD_RD_DATA: begin
                    rd_en = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_addr_d = rd_addr_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= bus.din[7:0];
        end
    end

    // Registered read: dout is a snapshot taken on the RD_DATA edge and
    // is unaffected by later writes to the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_en) begin
            dout_q <= mem[rd_addr_q];
        end
    end

    spi_ram_tx_timer #(
        .TX_HOLD (TX_HOLD)
    ) u_tx_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (rd_en),
        .tx_valid (tx_valid)
    );

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid;

endmodule : spi_ram

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed, table-driven check of spi_ram plus hand-written
// multi-cycle sequences (snapshot, re-trigger, interleave, reset, autoinc).
module tb_spi_ram;

    typedef struct {
        logic       rxv;
        logic [9:0] din;
        logic [7:0] exp_dout;
        logic       exp_tx;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    spi_ram_if bus ();

    spi_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one word at a negedge; return at the following negedge so the
    // outputs reflect the rising edge that sampled it.
    task automatic step(input logic rxv, input logic [9:0] d);
        bus.rx_valid = rxv;
        bus.din      = d;
        if (rxv)
            $display("[TB] t=%0t cmd=%0d byte=%02h", $time, d[9:8], d[7:0]);
        @(negedge clk);
    endtask

    // Idle until the TX window closes, bounded.
    task automatic drain();
        int n;
        n = 0;
        while (bus.tx_valid === 1'b1 && n < 20) begin
            step(1'b0, 10'h000);
            n++;
        end
        chk("drain_tx_low", {15'd0, bus.tx_valid}, 16'd0);
    endtask

    function automatic vec_t mk(input logic rxv, input logic [9:0] d,
                                input logic [7:0] ed, input logic et);
        vec_t v;
        v.rxv = rxv; v.din = d; v.exp_dout = ed; v.exp_tx = et;
        return v;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.din      = 10'h000;
        repeat (2) @(negedge clk);
        chk("reset_dout", {8'd0, bus.dout}, 16'h00);
        chk("reset_tx", {15'd0, bus.tx_valid}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Setup writes, then the basic write/read and a 9-cycle window.
        vecs.push_back(mk(1'b1, 10'h000, 8'h00, 1'b0)); // WR_ADDR 00
        vecs.push_back(mk(1'b1, 10'h13C, 8'h00, 1'b0)); // mem[00]=3C
        vecs.push_back(mk(1'b1, 10'h030, 8'h00, 1'b0)); // WR_ADDR 30
        vecs.push_back(mk(1'b1, 10'h177, 8'h00, 1'b0)); // mem[30]=77
        vecs.push_back(mk(1'b1, 10'h025, 8'h00, 1'b0)); // WR_ADDR 25
        vecs.push_back(mk(1'b1, 10'h1A5, 8'h00, 1'b0)); // mem[25]=A5
        vecs.push_back(mk(1'b1, 10'h225, 8'h00, 1'b0)); // RD_ADDR 25
        vecs.push_back(mk(1'b1, 10'h300, 8'hA5, 1'b1)); // RD_DATA
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b0, 10'h000, 8'hA5, 1'b1));
        vecs.push_back(mk(1'b0, 10'h000, 8'hA5, 1'b0)); // window over
        vecs.push_back(mk(1'b0, 10'h3FF, 8'hA5, 1'b0)); // RD_DATA ignored w/o rx_valid
        vecs.push_back(mk(1'b0, 10'h3FF, 8'hA5, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rxv, vecs[i].din);
            chk($sformatf("vec%0d_dout", i), {8'd0, bus.dout}, {8'd0, vecs[i].exp_dout});
            chk($sformatf("vec%0d_tx", i), {15'd0, bus.tx_valid}, {15'd0, vecs[i].exp_tx});
        end

        // Snapshot: write 5A to the read address mid-window; dout keeps A5.
        step(1'b1, 10'h225);
        step(1'b1, 10'h025);
        for (int s = 0; s < 12; s++) begin
            if (s == 0)      step(1'b1, 10'h300);
            else if (s == 1) step(1'b1, 10'h15A);
            else             step(1'b0, 10'h000);
            chk($sformatf("snap%0d_dout", s), {8'd0, bus.dout}, 16'h00A5);
            chk($sformatf("snap%0d_tx", s), {15'd0, bus.tx_valid}, (s < 9) ? 16'd1 : 16'd0);
        end
        step(1'b1, 10'h225);
        step(1'b1, 10'h300);
        chk("snap_reread_dout", {8'd0, bus.dout}, 16'h005A);
        drain();

        // Re-trigger four cycles into the window: 13 contiguous cycles.
        step(1'b1, 10'h225);
        for (int s = 0; s < 16; s++) begin
            if (s == 0)      step(1'b1, 10'h300);
            else if (s == 2) step(1'b1, 10'h230);
            else if (s == 4) step(1'b1, 10'h300);
            else             step(1'b0, 10'h000);
            chk($sformatf("retrig%0d_tx", s), {15'd0, bus.tx_valid}, (s < 13) ? 16'd1 : 16'd0);
            chk($sformatf("retrig%0d_dout", s), {8'd0, bus.dout}, (s < 4) ? 16'h005A : 16'h0077);
        end

        // Interleave: WR_ADDR/WR_DATA during the window leave it untouched.
        step(1'b1, 10'h225);
        for (int s = 0; s < 11; s++) begin
            if (s == 0)      step(1'b1, 10'h300);
            else if (s == 1) step(1'b1, 10'h010);
            else if (s == 3) step(1'b1, 10'h199);
            else             step(1'b0, 10'h000);
            chk($sformatf("ilv%0d_tx", s), {15'd0, bus.tx_valid}, (s < 9) ? 16'd1 : 16'd0);
            chk($sformatf("ilv%0d_dout", s), {8'd0, bus.dout}, 16'h005A);
        end
        step(1'b1, 10'h210);
        step(1'b1, 10'h300);
        chk("ilv_read10_dout", {8'd0, bus.dout}, 16'h0099);
        drain();

        // Reset in the middle of a window: outputs clear asynchronously,
        // rd_addr returns to 0.
        step(1'b1, 10'h230);
        step(1'b1, 10'h300);
        chk("rstmid_pre_dout", {8'd0, bus.dout}, 16'h0077);
        step(1'b0, 10'h000);
        step(1'b0, 10'h000);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx", {15'd0, bus.tx_valid}, 16'd0);
        chk("rstmid_dout", {8'd0, bus.dout}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 10'h000);
        chk("rstmid_stays_idle", {15'd0, bus.tx_valid}, 16'd0);
        step(1'b1, 10'h300);
        chk("rst_read0_dout", {8'd0, bus.dout}, 16'h003C);
        chk("rst_read0_tx", {15'd0, bus.tx_valid}, 16'd1);
        drain();

        // Address auto-increment with wrap at the top of memory.
        step(1'b1, 10'h0FF);
        step(1'b1, 10'h111);
        step(1'b1, 10'h122);
        step(1'b1, 10'h2FF);
        step(1'b1, 10'h300);
`ifdef SPI_RAM_AUTOINC_EN
        chk("ainc_memFF", {8'd0, bus.dout}, 16'h0011);
        step(1'b1, 10'h300);
        chk("ainc_mem00_wrap", {8'd0, bus.dout}, 16'h0022);
`else
        chk("noinc_memFF", {8'd0, bus.dout}, 16'h0022);
        step(1'b1, 10'h300);
        chk("noinc_reread", {8'd0, bus.dout}, 16'h0022);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_ram
